pll_reset_seq: RTL
==================

Name: pll_reset_seq

Overview:
Reset sequencer and lock supervisor for the Altera-style PLL instance (inputs areset/inclk0; outputs c0..c2/locked).
- Runs on the PLL reference clock (50 MHz, 20 ns period).
- Pulses pll_areset, waits for locked with a timeout, and debounces lock.
- Releases an active-low system reset only after lock has been stable for a set time.
- Re-sequences automatically on loss of lock or on software restart.

Parameters:
RST_CYCLES, 16, clk cycles pll_areset is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, clk cycles to wait for synchronized locked before declaring a timeout (1 ms)
STABLE_CYCLES, 1024, consecutive clk cycles locked_s must stay high before release
MAX_RETRY, 3, timeouts tolerated before FAIL (used only with PLL_AUTO_RETRY_EN)
CNT_W, 8, width of lock_loss_cnt

Ports:
clk  in  1  PLL reference clock (also drives inclk0)
rst_n  in  1  asynchronous active-low reset
restart  in  1  single-cycle pulse; forces a new sequence from any state
pll_locked  in  1  PLL locked output; asynchronous to clk
pll_areset  out  1  to PLL areset; active high
sys_rst_n  out  1  active-low reset for c0..c2 logic; low until RUN
ready  out  1  high only in RUN
fail  out  1  high only in FAIL
state  out  3  current state encoding for debug
lock_loss_cnt  out  CNT_W  saturating count of locked falls while in RUN

Behaviour:
Reset (rst_n=0, asynchronous):
- state=HOLD; pll_areset=1; sys_rst_n=0; ready=0; fail=0; lock_loss_cnt=0.
- All counters cleared; synchronizer flops cleared.

Lock synchronization:
- pll_locked passes through a 2-flop synchronizer to give locked_s.
- All decisions use locked_s only; 2-cycle latency.

States (encoding): HOLD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4.
- HOLD: pll_areset=1; count RST_CYCLES cycles, then go to WAIT with counter cleared. pll_areset falls on the first WAIT cycle.
- WAIT: pll_areset=0.
  - locked_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT-1 with locked_s=0: timeout (handling depends on optional feature).
- STABLE: count consecutive cycles with locked_s=1.
  - locked_s=0: return to WAIT with the timeout counter restarted; no retry is consumed.
  - Count reaches STABLE_CYCLES: go to RUN.
- RUN: sys_rst_n=1; ready=1.
  - locked_s=0: go to HOLD in the next cycle; lock_loss_cnt increments (saturates at all-ones); sys_rst_n drops the same cycle state leaves RUN.
- FAIL: pll_areset=1 (PLL held in reset); sys_rst_n=0; fail=1. Exit only via restart or rst_n.

Outputs and general rules:
- sys_rst_n is a registered output and deasserts synchronously: it goes 1 on the first RUN cycle, never combinationally.
- restart has priority over every transition. The next state is HOLD, counters clear, and the retry count clears. lock_loss_cnt is kept.
- restart while already in HOLD restarts the RST_CYCLES count.
- locked_s rising in the same cycle the timeout expires: lock wins and the state goes to STABLE.
- Every counter stops at its terminal value; none wraps.

Optional Feature:
Macro PLL_AUTO_RETRY_EN.
- Defined: a WAIT timeout increments retry_cnt and returns to HOLD. When retry_cnt reaches MAX_RETRY, the next timeout goes to FAIL. retry_cnt clears on entering RUN.
- Undefined: the first WAIT timeout goes directly to FAIL, and MAX_RETRY is ignored.

Test Plan:
1. rst_n released, pll_locked rises 100 cycles after pll_areset falls -> pll_areset high exactly 16 cycles; sys_rst_n rises at 16+100+2+1024 (+/-1) cycles; ready=1, state=3.
2. In RUN, pll_locked low for 5 cycles -> sys_rst_n=0 and state=0 within 3 cycles of the fall; lock_loss_cnt=1; after relock, RUN is re-entered and lock_loss_cnt stays 1.
3. pll_locked glitches low for 1 cycle at count 500 in STABLE -> state returns to WAIT, then STABLE; release occurs a full 1024 cycles after the glitch clears.
4. pll_locked tied 0, PLL_AUTO_RETRY_EN defined -> 4 HOLD pulses of 16 cycles, then fail=1, state=4, pll_areset=1. Undefined -> fail=1 after the first 50000-cycle timeout.
5. In FAIL, pulse restart with pll_locked=1 -> state=0, fail=0; sequence completes to RUN; lock_loss_cnt unchanged.
6. rst_n asserted in the middle of STABLE -> all outputs take their reset values immediately (asynchronously); counters are cleared.

Source files
------------

// File: rtl/pll_reset_seq_if.sv
// Control/status bundle between the PLL reset sequencer and its system-side user.
// The sequencer takes the slave modport; whoever drives restart and observes status takes master.
interface pll_reset_seq_if #(
    parameter int CNT_W = 8
);
    logic             restart;
    logic             pll_locked;
    logic             pll_areset;
    logic             sys_rst_n;
    logic             ready;
    logic             fail;
    logic [2:0]       state;
    logic [CNT_W-1:0] lock_loss_cnt;

    modport master (
        output restart, pll_locked,
        input  pll_areset, sys_rst_n, ready, fail, state, lock_loss_cnt
    );

    modport slave (
        input  restart, pll_locked,
        output pll_areset, sys_rst_n, ready, fail, state, lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer and lock supervisor: pulses areset, waits for a debounced lock, then releases sys_rst_n.
// Optional PLL_AUTO_RETRY_EN: retry the PLL reset up to MAX_RETRY times on lock timeout before failing.
//
// state  | meaning
// HOLD   | PLL areset asserted for RST_CYCLES
// WAIT   | areset released, waiting for locked_s (LOCK_TIMEOUT bound)
// STABLE | locked_s must stay high STABLE_CYCLES in a row
// RUN    | system reset released, supervising lock
// FAIL   | lock never achieved; PLL held in reset until restart
module pll_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pll_reset_seq_if.slave   bus
);
    localparam int M_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int M_B  = (STABLE_CYCLES > MAX_RETRY) ? STABLE_CYCLES : MAX_RETRY;
    localparam int TMAX = (M_A > M_B) ? M_A : M_B;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        RUN    = 3'd3,
        FAIL   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [1:0]       sync_q;
    logic             locked_s;
    logic             areset_q, sys_rst_n_q, ready_q, fail_q;

`ifdef PLL_AUTO_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0]    retry_q, retry_d;
`endif

    assign locked_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.pll_locked};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
`ifdef PLL_AUTO_RETRY_EN
        retry_d = retry_q;
`endif
        if (bus.restart) begin
            state_d = HOLD;
            cnt_d   = '0;
`ifdef PLL_AUTO_RETRY_EN
            retry_d = '0;
`endif
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == TW'(RST_CYCLES - 1)) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                WAIT: begin
                    // lock seen on the timeout cycle still counts as lock
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                        cnt_d = '0;
`ifdef PLL_AUTO_RETRY_EN
                        if (retry_q == RW'(MAX_RETRY)) begin
                            state_d = FAIL;
                        end else begin
                            state_d = HOLD;
                            retry_d = retry_q + RW'(1);
                        end
`else
                        state_d = FAIL;
`endif
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == TW'(STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
`ifdef PLL_AUTO_RETRY_EN
                        retry_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        if (loss_q != '1) begin
                            loss_d = loss_q + CNT_W'(1);
                        end
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // outputs are registered from the next state so they change together with state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            loss_q      <= '0;
            areset_q    <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            areset_q    <= (state_d == HOLD) || (state_d == FAIL);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);
        end
    end

`ifdef PLL_AUTO_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign bus.pll_areset    = areset_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.ready         = ready_q;
    assign bus.fail          = fail_q;
    assign bus.state         = state_q;
    assign bus.lock_loss_cnt = loss_q;

endmodule
